// File: rtl/vga_text_writer_if.sv
// ---------------------------------------------------------------------------
// vga_text_writer_if
//
// Bundles the byte-input handshake and the text-buffer write port of the
// text writer so that producer and consumer share one connection object.
//
// Signals
//   in_valid  producer -> writer   a character byte is being offered
//   in_char   producer -> writer   offered character code
//   in_ready  writer -> producer   writer accepts a byte this cycle
//   wr_en     writer -> buffer     one-cycle cell write strobe
//   wr_addr   writer -> buffer     cell address (row*cols + col)
//   wr_data   writer -> buffer     character written into the cell
//
// Modports
//   master  the side that offers bytes and observes the buffer writes
//   slave   the text writer itself
// ---------------------------------------------------------------------------
interface vga_text_writer_if #(
  parameter int addr_width = 15
) ();

  logic                  in_valid;
  logic [7:0]            in_char;
  logic                  in_ready;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [7:0]            wr_data;

  modport master (
    output in_valid,
    output in_char,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_char,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
//
// Turns a stream of character bytes into writes to a character-cell text
// buffer (one byte per 8x8 cell), keeping a cursor and interpreting a small
// set of control codes (LF, CR, BS, FF). Moving onto a new row clears that
// row; FF and reset clear the whole screen. While a clear is running the
// byte input is stalled.
//
// Parameters
//   h_disp, v_disp   visible pixel size; the cell grid is (h_disp/8) x (v_disp/8)
//
// Ports
//   clk              pixel clock, the only clock
//   reset            synchronous, active-high
//   bus (slave)      in_valid/in_char/in_ready byte handshake and the
//                    registered wr_en/wr_addr/wr_data buffer write port
//   cursor_x         column where the next printable character lands
//   cursor_y         row where the next printable character lands
//   busy             high while a line or screen clear is in progress
// ---------------------------------------------------------------------------
module vga_text_writer #(
  parameter  int h_disp     = 1280,
  parameter  int v_disp     = 1024,
  localparam int cols       = h_disp / 8,
  localparam int rows       = v_disp / 8,
  localparam int addr_width = $clog2(h_disp * v_disp / 64),
  localparam int x_width    = $clog2(cols),
  localparam int y_width    = $clog2(rows)
) (
  input  logic               clk,
  input  logic               reset,
  vga_text_writer_if.slave   bus,
  output logic [x_width-1:0] cursor_x,
  output logic [y_width-1:0] cursor_y,
  output logic               busy
);

  localparam logic [addr_width-1:0] cols_a      = addr_width'(cols);
  localparam logic [addr_width-1:0] line_span   = addr_width'(cols - 1);
  localparam logic [addr_width-1:0] screen_last = addr_width'(rows * cols - 1);
  localparam logic [x_width-1:0]    last_col    = x_width'(cols - 1);
  localparam logic [y_width-1:0]    last_row    = y_width'(rows - 1);
  localparam logic [7:0]            space_char  = 8'h20;

  localparam logic [7:0] char_bs = 8'h08;
  localparam logic [7:0] char_lf = 8'h0A;
  localparam logic [7:0] char_ff = 8'h0C;
  localparam logic [7:0] char_cr = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_SCREEN,
    CLEAR_LINE
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] clr_addr_q, clr_addr_d;
  logic [addr_width-1:0] clr_last_q, clr_last_d;
  logic [x_width-1:0]    cursor_x_q, cursor_x_d;
  logic [y_width-1:0]    cursor_y_q, cursor_y_d;
  logic                  wr_en_q, wr_en_d;
  logic [addr_width-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;

  logic                  in_ready;
  logic                  is_printable;
  logic                  start_line;
  logic [addr_width-1:0] cur_addr;
  logic [y_width-1:0]    next_row;
  logic [addr_width-1:0] next_base;

  // First cell address of a row. The row index is widened to the full
  // address width before multiplying so the product is never truncated.
  function automatic logic [addr_width-1:0] row_base(input logic [y_width-1:0] y);
    return addr_width'(y) * cols_a;
  endfunction

  // Cursor-derived helpers shared by the printable, LF and BS paths.
  // There is no scrolling: the row after the last one is row 0.
  always_comb begin
    cur_addr     = row_base(cursor_y_q) + addr_width'(cursor_x_q);
    next_row     = (cursor_y_q == last_row) ? '0 : cursor_y_q + y_width'(1);
    next_base    = row_base(next_row);
    is_printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
  end

  // Next-state and next-output logic. Every write goes through the wr_*_d
  // path so the buffer sees it one cycle after the byte was accepted (or one
  // cycle after the clear step that produced it). Both clear states walk
  // clr_addr from its start value up to clr_last, one cell per cycle; they
  // differ only in where they start and stop, which is loaded on entry.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_line = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = bus.in_char;
            if (cursor_x_q != last_col) begin
              cursor_x_d = cursor_x_q + x_width'(1);
            end else begin
              cursor_x_d = '0;
              cursor_y_d = next_row;
              start_line = 1'b1;
            end
          end else begin
            case (bus.in_char)
              char_lf: begin
                cursor_x_d = '0;
                cursor_y_d = next_row;
                start_line = 1'b1;
              end
              char_cr: begin
                cursor_x_d = '0;
              end
              // Backspace never crosses into the previous row, so the
              // erased cell is simply the one just before the cursor.
              char_bs: begin
                if (cursor_x_q != '0) begin
                  cursor_x_d = cursor_x_q - x_width'(1);
                  wr_en_d    = 1'b1;
                  wr_addr_d  = cur_addr - addr_width'(1);
                  wr_data_d  = space_char;
                end
              end
              char_ff: begin
                cursor_x_d = '0;
                cursor_y_d = '0;
                state_d    = CLEAR_SCREEN;
                clr_addr_d = '0;
                clr_last_d = screen_last;
              end
              default: begin
              end
            endcase
          end

          // Any move onto a new row blanks that row before more input.
          if (start_line) begin
            state_d    = CLEAR_LINE;
            clr_addr_d = next_base;
            clr_last_d = next_base + line_span;
          end
        end
      end

      CLEAR_SCREEN, CLEAR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = space_char;
        if (clr_addr_q == clr_last_q) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + addr_width'(1);
        end
      end

      default: begin
        state_d    = CLEAR_SCREEN;
        clr_addr_d = '0;
        clr_last_d = screen_last;
      end
    endcase
  end

  // State and output registers. Reset parks the block at the start of a
  // full-screen clear so the buffer is blanked as soon as reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_SCREEN;
      clr_addr_q <= '0;
      clr_last_q <= screen_last;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign bus.in_ready = in_ready;
  assign busy         = ~in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cursor_x     = cursor_x_q;
  assign cursor_y     = cursor_y_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
//
// Drives character bytes into vga_text_writer through its interface and
// predicts every text-buffer write with a cursor model built from plain
// row/column arithmetic. Predicted writes are queued when a byte is
// accepted; an independent monitor pops one entry for each wr_en pulse.
// Directed sequences cover reset, line wrap, LF/CR/BS/FF, bottom-row
// wrap-around and a byte held while the block is busy; a randomized run
// mixes printable and control codes in between.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

  localparam int h_disp     = 1280;
  localparam int v_disp     = 1024;
  localparam int cols       = h_disp / 8;
  localparam int rows       = v_disp / 8;
  localparam int addr_width = $clog2(h_disp * v_disp / 64);
  localparam int x_width    = $clog2(cols);
  localparam int y_width    = $clog2(rows);

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [x_width-1:0] cursor_x;
  logic [y_width-1:0] cursor_y;
  logic               busy;

  int  checks     = 0;
  int  failures   = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  cx         = 0;
  int  cy         = 0;
  int  model_busy = 0;
  int  last_wait  = 0;

  vga_text_writer_if #(.addr_width(addr_width)) bus ();

  vga_text_writer #(
    .h_disp(h_disp),
    .v_disp(v_disp)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pushLine(input int row);
    for (int i = 0; i < cols; i++) pushWrite(row * cols + i, 'h20);
    model_busy = cols;
  endtask

  task automatic pushScreen();
    for (int i = 0; i < rows * cols; i++) pushWrite(i, 'h20);
    model_busy = rows * cols;
  endtask

  // Reference behaviour of one accepted byte: cursor update plus the cell
  // writes it must cause, in the order they must appear.
  task automatic modelAccept(input int c);
    model_busy = 0;
    if (c >= 'h20 && c <= 'h7E) begin
      pushWrite(cy * cols + cx, c);
      cx++;
      if (cx == cols) begin
        cx = 0;
        cy = (cy + 1) % rows;
        pushLine(cy);
      end
    end else if (c == 'h0A) begin
      cx = 0;
      cy = (cy + 1) % rows;
      pushLine(cy);
    end else if (c == 'h0D) begin
      cx = 0;
    end else if (c == 'h08) begin
      if (cx > 0) begin
        cx--;
        pushWrite(cy * cols + cx, 'h20);
      end
    end else if (c == 'h0C) begin
      cx = 0;
      cy = 0;
      pushScreen();
    end
  endtask

  // Offers a byte and holds it until accepted. Called and returns just
  // after a falling edge; on return the DUT is one cycle past acceptance.
  task automatic applyStimulus(input logic [7:0] c);
    last_wait    = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && last_wait < 25000) begin
      last_wait++;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout char=%0h in_ready=%b required=1", c, bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      modelAccept(int'(c));
      #1;
      bus.in_valid = 1'b0;
      bus.in_char  = 8'($urandom);
      @(negedge clk);
      checkOutput("cursor_x", 32'(cursor_x), 32'(cx));
      checkOutput("cursor_y", 32'(cursor_y), 32'(cy));
    end
  endtask

  // Counts falling edges with in_ready low until the block is idle again.
  task automatic waitIdle(input int expected);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n <= expected + 16) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(n), 32'(expected));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkQueue();
    @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Holds reset, checks the reset outputs, then follows the full clear.
  task automatic doReset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("rst_cursor_y", 32'(cursor_y), 32'd0);
    cx = 0;
    cy = 0;
    pushScreen();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("clr_first_en", 32'(bus.wr_en), 32'd1);
    checkOutput("clr_first_addr", 32'(bus.wr_addr), 32'd0);
    waitIdle(rows * cols - 1);
    checkQueue();
  endtask

  // Scoreboard monitor: every write strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual addr=%0d data=%0h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] c;
    int         r;
    logic [7:0] others [6];

    others[0] = 8'h07;
    others[1] = 8'h00;
    others[2] = 8'hFF;
    others[3] = 8'h1B;
    others[4] = 8'h80;
    others[5] = 8'h7F;

    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    $display("[TB] reset and power-up clear");
    doReset();

    $display("[TB] single printable at origin");
    applyStimulus(8'h41);
    checkOutput("a_wr_en", 32'(bus.wr_en), 32'd1);
    checkOutput("a_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("a_wr_data", 32'(bus.wr_data), 32'h41);
    checkOutput("a_in_ready", 32'(bus.in_ready), 32'd1);
    waitIdle(0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom_range(32, 126)));
      waitIdle(0);
    end

    $display("[TB] line feed mid-row");
    checkOutput("pre_lf_x", 32'(cursor_x), 32'd5);
    applyStimulus(8'h0A);
    waitIdle(cols);
    checkQueue();

    $display("[TB] byte held while busy");
    applyStimulus(8'h0A);
    applyStimulus(8'h21);
    checkOutput("held_wait", 32'(last_wait), 32'(cols));
    waitIdle(0);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    waitIdle(0);

    $display("[TB] backspace, carriage return, ignored codes");
    checkOutput("pre_bs_x", 32'(cursor_x), 32'd3);
    checkOutput("pre_bs_y", 32'(cursor_y), 32'd2);
    applyStimulus(8'h08);
    checkOutput("bs_wr_en", 32'(bus.wr_en), 32'd1);
    checkOutput("bs_wr_addr", 32'(bus.wr_addr), 32'd322);
    checkOutput("bs_wr_data", 32'(bus.wr_data), 32'h20);
    waitIdle(0);
    applyStimulus(8'h0D);
    checkOutput("cr_wr_en", 32'(bus.wr_en), 32'd0);
    applyStimulus(8'h08);
    checkOutput("bs0_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("bs0_x", 32'(cursor_x), 32'd0);
    checkOutput("bs0_y", 32'(cursor_y), 32'd2);
    applyStimulus(8'h0D);
    checkOutput("cr2_wr_en", 32'(bus.wr_en), 32'd0);
    applyStimulus(8'h07);
    checkOutput("bel_wr_en", 32'(bus.wr_en), 32'd0);
    waitIdle(0);
    checkQueue();

    $display("[TB] randomized byte stream");
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75)      c = 8'($urandom_range(32, 126));
      else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 92) c = 8'h08;
      else             c = others[$urandom_range(0, 5)];
      applyStimulus(c);
      waitIdle(model_busy);
    end
    checkQueue();

    $display("[TB] walk to last cell and wrap");
    applyStimulus(8'h0D);
    waitIdle(0);
    while (cy != rows - 1) begin
      applyStimulus(8'h0A);
      waitIdle(model_busy);
    end
    while (cx != cols - 1) begin
      applyStimulus(8'($urandom_range(32, 126)));
      waitIdle(model_busy);
    end
    applyStimulus(8'h5A);
    checkOutput("wrap_wr_en", 32'(bus.wr_en), 32'd1);
    checkOutput("wrap_wr_addr", 32'(bus.wr_addr), 32'd20479);
    checkOutput("wrap_wr_data", 32'(bus.wr_data), 32'h5A);
    waitIdle(cols);
    checkOutput("wrap_x", 32'(cursor_x), 32'd0);
    checkOutput("wrap_y", 32'(cursor_y), 32'd0);
    checkQueue();

    $display("[TB] form feed");
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    applyStimulus(8'h0C);
    waitIdle(rows * cols);
    checkQueue();

    $display("[TB] reset during line clear");
    applyStimulus(8'h0A);
    repeat (39) @(negedge clk);
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 The block SHALL have parameter h_disp, default 1280, visible pixel width.
REQ-002 The block SHALL have parameter v_disp, default 1024, visible pixel height.
REQ-003 The block SHALL derive cols = h_disp/8, rows = v_disp/8, addr_width = $clog2(h_disp*v_disp/64), x_width = $clog2(cols), y_width = $clog2(rows); defaults 160, 128, 15, 8, 7.
REQ-004 The block SHALL have port clk, input, 1, the single clock (pixel clock domain).
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, character byte offered.
REQ-007 The block SHALL have port in_char, input, 8, offered character code.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts a byte this cycle.
REQ-009 The block SHALL have port wr_en, output, 1, text-buffer write strobe.
REQ-010 The block SHALL have port wr_addr, output, addr_width, text-buffer cell address.
REQ-011 The block SHALL have port wr_data, output, 8, character written.
REQ-012 The block SHALL have port cursor_x, output, x_width, current column.
REQ-013 The block SHALL have port cursor_y, output, y_width, current row.
REQ-014 The block SHALL have port busy, output, 1, high in any clear state.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR_SCREEN, CLEAR_LINE; in_ready = (state == IDLE); busy = !in_ready.
REQ-016 A byte SHALL be accepted only on a cycle with in_valid && in_ready; bytes offered while in_ready = 0 SHALL be neither consumed nor lost (the sender holds them).
REQ-017 Cell address SHALL be cursor_y*cols + cursor_x, computed at full addr_width without truncation.
REQ-018 wr_en, wr_addr, wr_data SHALL be registered: a write caused by an acceptance appears on the cycle after acceptance, wr_en is high for exactly one cycle per cell write, and wr_en is 0 otherwise.
REQ-019 Printable 0x20-0x7E: write in_char at the cursor cell; if cursor_x < cols-1, increment cursor_x and stay in IDLE.
REQ-020 Printable at cursor_x = cols-1: write the char; set cursor_x = 0 and cursor_y to the next row; enter CLEAR_LINE.
REQ-021 0x0A (LF): set cursor_x = 0 and cursor_y to the next row; enter CLEAR_LINE; no character write.
REQ-022 0x0D (CR): set cursor_x = 0; no write; stay in IDLE.
REQ-023 0x08 (BS): if cursor_x > 0, decrement cursor_x and write 0x20 at the new cell; if cursor_x = 0, do nothing (no write, no row change).
REQ-024 0x0C (FF): set the cursor to (0,0) and enter CLEAR_SCREEN.
REQ-025 All other codes SHALL be consumed with no write and no cursor change.
REQ-026 Next row SHALL be cursor_y+1, wrapping from rows-1 to 0; no scrolling.
REQ-027 CLEAR_LINE SHALL write 0x20 to cells row*cols .. row*cols+cols-1 of the new row in ascending order, one per cycle, on cols consecutive cycles. The first clear write is on the cycle after any char write from REQ-020, which is itself on the cycle after acceptance. The state then returns to IDLE.
REQ-028 CLEAR_SCREEN SHALL write 0x20 to addresses 0 .. rows*cols-1 in ascending order, one per cycle, then return to IDLE.
REQ-029 The cursor SHALL not change during clear states; cursor_x/cursor_y always reflect the position for the next printable character.

Reset
REQ-030 While reset is high: state = CLEAR_SCREEN with the internal clear counter at 0; cursor_x = 0, cursor_y = 0; wr_en = 0, wr_addr = 0, wr_data = 0; in_ready = 0; busy = 1.
REQ-031 After reset deasserts, the block SHALL perform a full CLEAR_SCREEN starting with address 0 on the first cycle. Reset asserted during any state, including mid-clear, SHALL abort that operation and restart per REQ-030.

Verification
REQ-032 Release reset -> 20480 consecutive wr_en pulses with wr_data 0x20 at addresses 0..20479, in_ready = 0 throughout; then in_ready = 1 and cursor = (0,0).
REQ-033 From (0,0), send 0x41 -> next cycle wr_en = 1, wr_addr = 0, wr_data = 0x41; cursor = (1,0); in_ready stays 1.
REQ-034 At (5,0), send 0x0A -> cursor = (0,1); 160 writes of 0x20 at addresses 160..319; in_ready low for exactly 160 cycles.
REQ-035 At (159,127), send 0x5A -> a write of 0x5A at address 20479, then 0x20 at addresses 0..159; final cursor = (0,0).
REQ-036 At (3,2), send 0x08 -> a write of 0x20 at address 322 and cursor = (2,2). Then at (0,2), send 0x08 -> no write, cursor unchanged; 0x0D and 0x07 -> no write.
REQ-037 Assert reset 40 cycles into a CLEAR_LINE -> outputs match REQ-030; after release, a full clear restarts at address 0. Also, hold in_valid during busy -> the byte is accepted only once in_ready returns.
